// File: rtl/microwave_pkg.sv
// ============================================================================
// Module  : microwave_pkg
// Brief   : Shared state encoding and constants for the microwave cook timer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package microwave_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      ARMED    = 3'd1,
      STARTING = 3'd2,
      RUN      = 3'd3,
      HOLD     = 3'd4,
      DONE     = 3'd5
   } timer_state_t;

   localparam int ADD_SECONDS = 30;

endpackage

`default_nettype wire

// File: rtl/microwave_cook_timer_prescaler.sv
// ============================================================================
// Module  : tick_prescaler
// Brief   : Free-running 1 s tick generator; count freezes while en is low.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_prescaler #(
   parameter int TICK_DIV = 50_000_000
) (
   input  logic clk,
   input  logic nrst,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int             CW     = $clog2(TICK_DIV);
   localparam logic [CW-1:0]  C_LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] r_cnt;

   assign tick = en & (r_cnt == C_LAST);

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_cnt <= '0;
      end else if (clr) begin
         r_cnt <= '0;
      end else if (en) begin
         r_cnt <= (r_cnt == C_LAST) ? '0 : r_cnt + CW'(1);
      end
   end

endmodule

`default_nettype wire

// File: rtl/microwave_cook_timer.sv
// ============================================================================
// Module  : microwave_cook_timer
// Brief   : Cook-time sequencer; counts seconds down while heat is on.
//           `define ADD30_EN adds the add30 (+30 s) input.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module microwave_cook_timer
   import microwave_pkg::*;
#(
   parameter int TW       = 12,
   parameter int TICK_DIV = 50_000_000
) (
   input  logic          clk,
   input  logic          nrst,
   input  logic [TW-1:0] time_in,
   input  logic          load,
   input  logic          start_btn,
   input  logic          cancel,
   input  logic          heat,
   input  logic          bell,
`ifdef ADD30_EN
   input  logic          add30,
`endif
   output logic          start,
   output logic          finish,
   output logic [TW-1:0] remaining,
   output logic          busy
);

   timer_state_t  r_state;
   timer_state_t  w_nxt;
   logic [TW-1:0] r_rem;
   logic [TW-1:0] w_rem_nxt;
   logic [TW-1:0] w_base;
   logic          r_start;
   logic          r_finish;
   logic          r_busy;
   logic          w_en;
   logic          w_clr;
   logic          w_tick;

   assign w_en  = (r_state == RUN) & heat;
   assign w_clr = (r_state == STARTING) & heat & ~cancel;

   tick_prescaler #(
      .TICK_DIV (TICK_DIV)
   ) u_prescaler (
      .clk  (clk),
      .nrst (nrst),
      .en   (w_en),
      .clr  (w_clr),
      .tick (w_tick)
   );

`ifdef ADD30_EN
   function automatic logic [TW-1:0] sat_add(input logic [TW-1:0] v);
      logic [TW:0] s;
      s = {1'b0, v} + (TW+1)'(ADD_SECONDS);
      return s[TW] ? '1 : s[TW-1:0];
   endfunction
`endif

   always_comb begin
      w_nxt     = r_state;
      w_rem_nxt = r_rem;
      w_base    = r_rem;
      case (r_state)
         IDLE: begin
`ifdef ADD30_EN
            if (add30 && !cancel) begin
               w_nxt     = STARTING;
               w_rem_nxt = TW'(ADD_SECONDS);
            end else
`endif
            if (load && (time_in != '0)) begin
               w_nxt     = ARMED;
               w_rem_nxt = time_in;
            end
         end
         ARMED: begin
            if (cancel) begin
               w_nxt     = IDLE;
               w_rem_nxt = '0;
            end else begin
               if (start_btn) w_nxt = STARTING;
`ifdef ADD30_EN
               if (add30) w_rem_nxt = sat_add(r_rem); else
`endif
               if (load && (time_in != '0)) w_rem_nxt = time_in;
            end
         end
         STARTING: begin
            if (cancel) begin
               w_nxt     = IDLE;
               w_rem_nxt = '0;
            end else if (heat) begin
               w_nxt = RUN;
            end
         end
         RUN: begin
            if (cancel) begin
               w_nxt     = DONE;
               w_rem_nxt = '0;
            end else begin
               // tick only exists while heat=1, so a HOLD entry never loses a decrement
               if (!heat) w_nxt = HOLD;
               w_base    = (w_tick && (r_rem != '0)) ? r_rem - TW'(1) : r_rem;
               w_rem_nxt = w_base;
`ifdef ADD30_EN
               if (add30) w_rem_nxt = sat_add(w_base);
`endif
               if (w_tick && (w_rem_nxt == '0)) w_nxt = DONE;
            end
         end
         HOLD: begin
            if (cancel) begin
               w_nxt     = DONE;
               w_rem_nxt = '0;
            end else begin
               if (heat) w_nxt = RUN;
`ifdef ADD30_EN
               if (add30) w_rem_nxt = sat_add(r_rem);
`endif
            end
         end
         DONE: begin
            if (bell) w_nxt = IDLE;
         end
         default: begin
            w_nxt     = IDLE;
            w_rem_nxt = '0;
         end
      endcase
   end

   // Outputs are registered from the next state so they align with r_state.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_state  <= IDLE;
         r_rem    <= '0;
         r_start  <= 1'b0;
         r_finish <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_state  <= w_nxt;
         r_rem    <= w_rem_nxt;
         r_start  <= (w_nxt == STARTING);
         r_finish <= (w_nxt == DONE);
         r_busy   <= (w_nxt != IDLE);
      end
   end

   assign start     = r_start;
   assign finish    = r_finish;
   assign remaining = r_rem;
   assign busy      = r_busy;

endmodule

`default_nettype wire
